icache: RTL

- Direct-mapped instruction cache between the pc unit and mem_control inside cpu.
- Serves pc fetch requests from local storage on a hit.
- On a miss, fills a whole multi-word line through mem_control's instruction port, one word per request.
- Honours ROB flush (clear) and rdy stall.

---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_tag_array.sv | 41 ++++
 rtl/icache.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared widths and FSM state encodings for the instruction cache.
package icache_pkg;

    localparam int unsigned addrWidth = 32;
    localparam int unsigned instWidth = 32;

    typedef enum logic [1:0] {
        ICACHE_IDLE = 2'd0,
        ICACHE_REQ  = 2'd1,
        ICACHE_WAIT = 2'd2,
        ICACHE_DONE = 2'd3
    } icache_state_e;

endpackage

// File: rtl/icache_tag_array.sv
// Valid + tag storage for the direct-mapped icache: one async read port, one write port.
// Valid bits clear asynchronously on reset; tags are not reset.
module icache_tag_array #(
    parameter int unsigned INDEX_WIDTH = 6,
    parameter int unsigned TAG_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] i_rd_idx,
    output logic                   o_rd_valid,
    output logic [TAG_WIDTH-1:0]   o_rd_tag,
    input  logic                   i_wr_en,
    input  logic [INDEX_WIDTH-1:0] i_wr_idx,
    input  logic                   i_wr_valid,
    input  logic [TAG_WIDTH-1:0]   i_wr_tag
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;

    logic [LINES-1:0]     r_valid;
    logic [TAG_WIDTH-1:0] r_tag [LINES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
        end
    end

    // Invalidation leaves the stale tag in place; only a completed fill rewrites it.
    always_ff @(posedge clk) begin
        if (i_wr_en && i_wr_valid) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: 1-cycle hit, word-by-word line fill through mem_control.
// Define ICACHE_PERF_EN to add hit_cnt/miss_cnt lookup counters.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = addrWidth,
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_get_pc,
    input  logic [ADDR_WIDTH-1:0] pc_get,
    output logic                  if_out_inst,
    output logic [instWidth-1:0]  inst_out,
    output logic                  if_req_mem,
    output logic [ADDR_WIDTH-1:0] addr_to_mem,
    input  logic                  if_got_inst,
    input  logic [instWidth-1:0]  inst_mem,
    input  logic                  clear
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int unsigned WORDS     = 1 << (INDEX_WIDTH + OFFSET_WIDTH);
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

    icache_state_e             r_state, w_state_d;
    logic [OFFSET_WIDTH-1:0]   r_cnt, w_cnt_d, r_off;
    logic [INDEX_WIDTH-1:0]    r_idx;
    logic [TAG_WIDTH-1:0]      r_tag;
    logic                      r_out, w_out_d, r_req, w_req_d;
    logic [instWidth-1:0]      r_inst, w_inst_d;
    logic [ADDR_WIDTH-1:0]     r_addr, w_addr_d;
    logic [instWidth-1:0]      r_data [WORDS];

    logic [OFFSET_WIDTH-1:0]   w_pc_off;
    logic [INDEX_WIDTH-1:0]    w_pc_idx, w_tag_widx;
    logic [TAG_WIDTH-1:0]      w_pc_tag, w_rd_tag, w_tag_wtag;
    logic                      w_rd_valid, w_hit, w_lookup, w_latch;
    logic                      w_tag_we, w_tag_wvalid, w_data_we;
    logic                      w_unused;

    assign w_pc_off = pc_get[OFFSET_WIDTH+1:2];
    assign w_pc_idx = pc_get[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign w_pc_tag = pc_get[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign w_unused = ^pc_get[1:0];

    icache_tag_array #(
        .INDEX_WIDTH(INDEX_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH)
    ) u_tag_array (
        .clk       (clk),
        .rst       (rst),
        .i_rd_idx  (w_pc_idx),
        .o_rd_valid(w_rd_valid),
        .o_rd_tag  (w_rd_tag),
        .i_wr_en   (rdy && w_tag_we),
        .i_wr_idx  (w_tag_widx),
        .i_wr_valid(w_tag_wvalid),
        .i_wr_tag  (w_tag_wtag)
    );

    assign w_hit = w_rd_valid && (w_rd_tag == w_pc_tag);
    // A request already answered last cycle must not be looked up again.
    assign w_lookup = (r_state == ICACHE_IDLE) && if_get_pc && !r_out && !clear;

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_out_d      = 1'b0;
        w_inst_d     = r_inst;
        w_req_d      = 1'b0;
        w_addr_d     = r_addr;
        w_latch      = 1'b0;
        w_tag_we     = 1'b0;
        w_tag_widx   = w_pc_idx;
        w_tag_wvalid = 1'b0;
        w_tag_wtag   = r_tag;
        w_data_we    = 1'b0;
        if (clear) begin
            w_state_d = ICACHE_IDLE;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                ICACHE_IDLE: begin
                    if (w_lookup) begin
                        if (w_hit) begin
                            w_out_d  = 1'b1;
                            w_inst_d = r_data[{w_pc_idx, w_pc_off}];
                        end else begin
                            w_latch   = 1'b1;
                            w_tag_we  = 1'b1;
                            w_cnt_d   = '0;
                            w_state_d = ICACHE_REQ;
                        end
                    end
                end
                ICACHE_REQ: begin
                    w_req_d   = 1'b1;
                    w_addr_d  = {r_tag, r_idx, r_cnt, 2'b00};
                    w_state_d = ICACHE_WAIT;
                end
                ICACHE_WAIT: begin
                    if (if_got_inst) begin
                        w_data_we = 1'b1;
                        if (r_cnt == LAST_WORD) begin
                            w_tag_we     = 1'b1;
                            w_tag_widx   = r_idx;
                            w_tag_wvalid = 1'b1;
                            w_state_d    = ICACHE_DONE;
                        end else begin
                            w_cnt_d   = r_cnt + 1'b1;
                            w_state_d = ICACHE_REQ;
                        end
                    end
                end
                ICACHE_DONE: begin
                    // Last fill word was committed on the previous edge, so a plain read suffices.
                    w_out_d   = 1'b1;
                    w_inst_d  = r_data[{r_idx, r_off}];
                    w_state_d = ICACHE_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ICACHE_IDLE;
            r_cnt   <= '0;
            r_off   <= '0;
            r_idx   <= '0;
            r_tag   <= '0;
            r_out   <= 1'b0;
            r_inst  <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else if (rdy) begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_out   <= w_out_d;
            r_inst  <= w_inst_d;
            r_req   <= w_req_d;
            r_addr  <= w_addr_d;
            if (w_latch) begin
                r_off <= w_pc_off;
                r_idx <= w_pc_idx;
                r_tag <= w_pc_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && w_data_we) begin
            r_data[{r_idx, r_cnt}] <= inst_mem;
        end
    end

    assign if_out_inst = r_out;
    assign inst_out    = r_inst;
    assign if_req_mem  = r_req;
    assign addr_to_mem = r_addr;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (rdy && w_lookup) begin
            if (w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
            else       r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
